// File: rtl/pwm_led_driver.sv
// ============================================================================
// Module  : pwm_led_driver
// Brief   : Fixed-period PWM LED driver; duty sampled at period boundaries.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_led_driver #(
    parameter int WIDTH      = 8,
    parameter int PRESCALER  = 0,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out,
    output logic             period_start,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] duty_sh;
    logic             tick;
    logic             wrap;
    logic             reload;
    logic             led_on;

    // Prescaler is a clock enable only; it restarts from zero every time the
    // driver leaves IDLE so each period is exactly 2^(WIDTH+PRESCALER) clks.
    if (PRESCALER > 0) begin : g_prescale
        logic [PRESCALER-1:0] pre_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pre_cnt <= '0;
            end else if (state == IDLE) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end

        assign tick = &pre_cnt;
    end else begin : g_no_prescale
        assign tick = 1'b1;
    end

    assign wrap = tick && (pwm_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        reload     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                    reload     = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (enable) begin
                        reload = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Re-enable before the wrap resumes the running period untouched.
                if (wrap) begin
                    if (enable) begin
                        state_next = RUN;
                        reload     = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (enable) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Full-scale duty stays on across the wrap instead of dropping one tick.
        led_on = (state != IDLE) && ((duty_sh == CNT_MAX) || (pwm_cnt < duty_sh));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            duty_sh      <= '0;
            period_start <= 1'b0;
            busy         <= 1'b0;
            pwm_out      <= ACTIVE_LOW;
        end else begin
            period_start <= reload;
            busy         <= (state_next != IDLE);
            pwm_out      <= led_on ^ ACTIVE_LOW;
            if (reload) begin
                duty_sh <= duty;
            end
            if (state == IDLE) begin
                pwm_cnt <= '0;
            end else if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
